mem_data_bridge: RTL and testbench
==================================

Name: mem_data_bridge

Overview:
MEM-stage data-side master that consumes the load/store request registered by the EX/MEM pipeline register. It drives an SRAM-like split-handshake bus (req/addr_ok/data_ok) and returns aligned, extended load data to MEM. It raises data_stall (stall[3]) to hold EX/MEM and earlier stages until the access completes, and drains in-flight transactions across exception flushes.

Parameters:
ADDR_WIDTH, 32, width of mem_addr and data_sram_addr

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
exception  in  1  pipeline flush; same meaning as the EX/MEM flush input
mem_load  in  1  MEM-stage instruction is a load
mem_store  in  1  MEM-stage instruction is a store
mem_size  in  2  0=byte, 1=half, 2=word; 3 treated as word
mem_sign_ext  in  1  loads: 1=sign-extend, 0=zero-extend
mem_addr  in  ADDR_WIDTH  effective address (EX/MEM mem_ram_read_addr / mem_ram_write_addr)
mem_wdata  in  32  store data, right-aligned
data_sram_req  out  1  bus request
data_sram_wr  out  1  1=write
data_sram_size  out  2  0/1/2 = 1/2/4 bytes
data_sram_addr  out  ADDR_WIDTH  byte address, passed unmodified
data_sram_wstrb  out  4  byte enables (0 on reads)
data_sram_wdata  out  32  lane-replicated store data
data_sram_addr_ok  in  1  request accepted this cycle
data_sram_data_ok  in  1  read data valid / write done this cycle
data_sram_rdata  in  32  read data, word-aligned lanes
mem_load_data  out  32  extended load result, registered
data_stall  out  1  hold EX/MEM and upstream stages
addr_err_load  out  1  misaligned load, combinational
addr_err_store  out  1  misaligned store, combinational

Behaviour:
- Access condition: access = (mem_load | mem_store) & ~misaligned & ~exception.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. A misaligned access raises addr_err_load or addr_err_store and issues no bus request; data_stall stays 0 for it.
- FSM states are IDLE, REQ, WAIT, DONE, DRAIN. All reset to IDLE. Reset values: mem_load_data=0, data_stall=0, data_sram_req=0.
- IDLE: if access, go to REQ. data_stall=1 combinationally in this cycle.
- REQ: data_sram_req=1; wr/size/addr/wstrb/wdata are combinational from the MEM inputs, which are held by the stall.
  - addr_ok & data_ok: go to DONE and capture rdata.
  - addr_ok only: go to WAIT.
  - exception before addr_ok: go to IDLE and drop req.
  - data_stall=1.
- WAIT: req=0, data_stall=1.
  - data_ok: capture extended rdata into mem_load_data, go to DONE.
  - exception: go to DRAIN.
- DONE: data_stall=0 and req=0 for one cycle, so EX/MEM advances. Next state is IDLE; no re-issue of the same instruction.
- DRAIN: req=0, data_stall=1. On data_ok, discard the data and leave mem_load_data unchanged, then go to IDLE. exception in DRAIN is ignored.
- Minimum aligned access latency: 4 cycles (IDLE, REQ, WAIT, DONE), with data_stall high for 3 of them. With addr_ok and data_ok both in REQ: 3 cycles, stall high for 2.
- Store lanes:
  - sb: wstrb = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 4'b1111, wdata = wdata.
- Load extract:
  - byte: rdata[8*addr[1:0] +: 8].
  - half: rdata[16*addr[1] +: 16].
  - Extension per mem_sign_ext.
- If mem_load and mem_store are both 1, treat the access as a store.
- Asynchronous rst in any state: go to IDLE immediately, outputs to reset values. An in-flight bus transaction is abandoned; the bus is reset together with the CPU.

Test Plan:
- lw at 0x1000, addr_ok in REQ, data_ok one cycle later with rdata=0x8badf00d → stall high 3 cycles, mem_load_data=0x8badf00d in DONE, no second req.
- lb sign at 0x1003, rdata=0x80000000 → 0xffffff80; lbu → 0x00000080; lh at 0x1002, rdata=0x8001xxxx → 0xffff8001.
- sb 0xAB at 0x2001 → req with wr=1, size=0, wstrb=0010, wdata=0xABABABAB; sh 0x1234 at 0x2002 → wstrb=1100, wdata=0x12341234.
- lw at 0x1002 → addr_err_load=1, no req, data_stall=0; sh at 0x2001 → addr_err_store=1, no req.
- addr_ok withheld 5 cycles → req stays high with stable addr, stall stays high. Then exception in WAIT → DRAIN; data_ok with 0xdeadbeef leaves mem_load_data unchanged, then IDLE.
- rst pulsed mid-WAIT (asynchronous, off-edge) → req=0, data_stall=0, mem_load_data=0 immediately; next access proceeds normally.

Source files
------------

// File: rtl/mem_data_bridge.sv
// mem_data_bridge
// MEM-stage data-side bus master. Takes the load/store held in EX/MEM, issues
// it on an SRAM-like split bus (req/addr_ok/data_ok), returns the aligned and
// extended load result, and stalls the pipeline until the access completes.
// A transaction already accepted when a flush arrives is drained before the
// block returns to idle.
//
// Bus handshake: a request is accepted in the cycle where data_sram_req and
// data_sram_addr_ok are both 1; its response is the first cycle, either that
// same cycle or a later one, in which data_sram_data_ok is 1. The request
// fields only need to be valid while data_sram_req is 1.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   exception              pipeline flush
//   mem_load, mem_store    MEM-stage access kind (both set = store)
//   mem_size               0 byte, 1 half, 2/3 word
//   mem_sign_ext           load extension select
//   mem_addr, mem_wdata    effective address, right-aligned store data
//   data_sram_*            bus request / response
//   mem_load_data          registered extended load result
//   data_stall             hold EX/MEM and earlier stages
//   addr_err_load/store    misaligned access flags (combinational)
module mem_data_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exception,
    input  logic                  mem_load,
    input  logic                  mem_store,
    input  logic [1:0]            mem_size,
    input  logic                  mem_sign_ext,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  data_sram_req,
    output logic                  data_sram_wr,
    output logic [1:0]            data_sram_size,
    output logic [ADDR_WIDTH-1:0] data_sram_addr,
    output logic [3:0]            data_sram_wstrb,
    output logic [31:0]           data_sram_wdata,
    input  logic                  data_sram_addr_ok,
    input  logic                  data_sram_data_ok,
    input  logic [31:0]           data_sram_rdata,
    output logic [31:0]           mem_load_data,
    output logic                  data_stall,
    output logic                  addr_err_load,
    output logic                  addr_err_store
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] load_data_q, load_data_d;

    logic        is_load;
    logic [1:0]  size_eff;
    logic        misaligned;
    logic        access;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // A load with mem_store also set is treated as a store.
    assign is_load  = mem_load & ~mem_store;
    assign size_eff = (mem_size == 2'd3) ? 2'd2 : mem_size;

    assign misaligned = ((size_eff == 2'd1) & mem_addr[0]) |
                        ((size_eff == 2'd2) & (mem_addr[1:0] != 2'b00));
    assign access     = (mem_load | mem_store) & ~misaligned & ~exception;

    assign addr_err_load  = is_load & misaligned;
    assign addr_err_store = mem_store & misaligned;

    // Request fields come straight from the MEM inputs, which the stall holds.
    assign data_sram_req  = (state_q == S_REQ);
    assign data_sram_wr   = mem_store;
    assign data_sram_size = size_eff;
    assign data_sram_addr = mem_addr;

    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = mem_wdata;
        if (mem_store) begin
            case (size_eff)
                2'd0: begin
                    data_sram_wstrb = 4'b0001 << mem_addr[1:0];
                    data_sram_wdata = {4{mem_wdata[7:0]}};
                end
                2'd1: begin
                    data_sram_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
                    data_sram_wdata = {2{mem_wdata[15:0]}};
                end
                default: begin
                    data_sram_wstrb = 4'b1111;
                    data_sram_wdata = mem_wdata;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the word-aligned read data and extend it.
    always_comb begin
        byte_sel = data_sram_rdata[{mem_addr[1:0], 3'b000} +: 8];
        half_sel = data_sram_rdata[{mem_addr[1], 4'b0000} +: 16];
        case (size_eff)
            2'd0:    load_ext = {{24{mem_sign_ext & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{mem_sign_ext & half_sel[15]}}, half_sel};
            default: load_ext = data_sram_rdata;
        endcase
    end

    // Stall starts combinationally in the IDLE cycle that sees a new access
    // and drops in DONE so EX/MEM advances exactly once per access.
    // It is forced low while reset is asserted.
    assign data_stall = ~rst & (((state_q == S_IDLE) & access) |
                                (state_q == S_REQ) |
                                (state_q == S_WAIT) |
                                (state_q == S_DRAIN));

    assign mem_load_data = load_data_q;

    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (access) state_d = S_REQ;
            end
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    if (data_sram_data_ok) begin
                        // Accepted and answered at once: nothing left to drain.
                        if (exception) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DONE;
                            if (is_load) load_data_d = load_ext;
                        end
                    end else begin
                        state_d = exception ? S_DRAIN : S_WAIT;
                    end
                end else if (exception) begin
                    // Not yet accepted, so the request can simply be withdrawn.
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    // A flush coinciding with the response just discards it.
                    if (exception) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (is_load) load_data_d = load_ext;
                    end
                end else if (exception) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (data_sram_data_ok) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
        end
    end

endmodule

// File: tb/tb_mem_data_bridge.sv
module tb_mem_data_bridge;

    logic        clk;
    logic        rst;
    logic        exception;
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_size;
    logic        mem_sign_ext;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [31:0] mem_load_data;
    logic        data_stall;
    logic        addr_err_load;
    logic        addr_err_store;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model_load_data;

    mem_data_bridge #(.ADDR_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .exception         (exception),
        .mem_load          (mem_load),
        .mem_store         (mem_store),
        .mem_size          (mem_size),
        .mem_sign_ext      (mem_sign_ext),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_load_data     (mem_load_data),
        .data_stall        (data_stall),
        .addr_err_load     (addr_err_load),
        .addr_err_store    (addr_err_store)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // Reference model: plain arithmetic on byte counts and offsets.
    function automatic int bytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit sext,
                                             input logic [31:0] addr, input logic [31:0] rd);
        int nb;
        longint unsigned v, mask;
        nb   = bytes_of(sz);
        v    = longint'(rd);
        v    = v >> (8 * int'(addr[1:0]));
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (sext && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic [1:0] sz, input logic [31:0] addr);
        int s;
        s = ((1 << bytes_of(sz)) - 1) << int'(addr[1:0]);
        return s[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = bytes_of(sz);
        r  = 32'd0;
        for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % nb))) & 32'hff) << (8 * i));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        exception         = 1'b0;
        mem_load          = 1'b0;
        mem_store         = 1'b0;
        mem_size          = 2'd0;
        mem_sign_ext      = 1'b0;
        mem_addr          = 32'd0;
        mem_wdata         = 32'd0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
    endtask

    // One aligned access: addr_ok after aok_dly REQ cycles, data_ok dok_dly
    // cycles after addr_ok (0 = same cycle).
    task automatic do_access(input string tag, input bit ld, input bit st,
                             input logic [1:0] sz, input bit sext,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int aok_dly, input int dok_dly);
        int stall_cycles;
        bit is_st;
        is_st = st;
        stall_cycles = 0;
        @(negedge clk);
        mem_load = ld; mem_store = st; mem_size = sz; mem_sign_ext = sext;
        mem_addr = addr; mem_wdata = wd; exception = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        check({tag, " idle_req"}, 32'(data_sram_req), 32'd0);
        if (data_stall) stall_cycles++;
        for (int k = 0; k <= aok_dly; k++) begin
            @(negedge clk);
            data_sram_addr_ok = (k == aok_dly);
            data_sram_data_ok = (k == aok_dly) && (dok_dly == 0);
            data_sram_rdata   = data_sram_data_ok ? rd : $urandom;
            #1;
            check({tag, " req"}, 32'(data_sram_req), 32'd1);
            check({tag, " addr"}, data_sram_addr, addr);
            check({tag, " wr"}, 32'(data_sram_wr), 32'(is_st));
            check({tag, " size"}, 32'(data_sram_size), 32'(bytes_of(sz) == 4 ? 2 : sz));
            check({tag, " wstrb"}, 32'(data_sram_wstrb), is_st ? 32'(exp_wstrb(sz, addr)) : 32'd0);
            if (is_st) check({tag, " wdata"}, data_sram_wdata, exp_wdata(sz, wd));
            if (data_stall) stall_cycles++;
        end
        for (int k = 1; k <= dok_dly; k++) begin
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = (k == dok_dly);
            data_sram_rdata   = data_sram_data_ok ? rd : $urandom;
            #1;
            check({tag, " wait_req"}, 32'(data_sram_req), 32'd0);
            if (data_stall) stall_cycles++;
        end
        if (ld && !st) model_load_data = exp_load(sz, sext, addr, rd);
        @(negedge clk);
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        #1;
        check({tag, " done_stall"}, 32'(data_stall), 32'd0);
        check({tag, " done_req"}, 32'(data_sram_req), 32'd0);
        if (ld && !st) check({tag, " load_data"}, mem_load_data, model_load_data);
        check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(1 + (aok_dly + 1) + dok_dly));
        @(negedge clk);
        mem_load = 1'b0; mem_store = 1'b0;
        #1;
        check({tag, " no_reissue"}, 32'(data_sram_req), 32'd0);
        check({tag, " idle_stall"}, 32'(data_stall), 32'd0);
    endtask

    task automatic do_misaligned(input string tag, input bit ld, input bit st,
                                 input logic [1:0] sz, input logic [31:0] addr,
                                 input bit e_ld, input bit e_st);
        @(negedge clk);
        mem_load = ld; mem_store = st; mem_size = sz; mem_addr = addr;
        mem_wdata = $urandom;
        #1;
        check({tag, " err_load"}, 32'(addr_err_load), 32'(e_ld));
        check({tag, " err_store"}, 32'(addr_err_store), 32'(e_st));
        check({tag, " stall"}, 32'(data_stall), 32'd0);
        @(negedge clk);
        #1;
        check({tag, " req"}, 32'(data_sram_req), 32'd0);
        check({tag, " stall2"}, 32'(data_stall), 32'd0);
        @(negedge clk);
        mem_load = 1'b0; mem_store = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_load_data = 32'd0;

        // Reset state
        rst = 1'b1;
        #3;
        check("reset req", 32'(data_sram_req), 32'd0);
        check("reset stall", 32'(data_stall), 32'd0);
        check("reset load_data", mem_load_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed loads and stores
        do_access("lw", 1, 0, 2'd2, 0, 32'h1000, 32'd0, 32'h8badf00d, 0, 1);
        do_access("lb", 1, 0, 2'd0, 1, 32'h1003, 32'd0, 32'h80000000, 0, 1);
        do_access("lbu", 1, 0, 2'd0, 0, 32'h1003, 32'd0, 32'h80000000, 0, 1);
        do_access("lh", 1, 0, 2'd1, 1, 32'h1002, 32'd0, 32'h80015a5a, 0, 1);
        do_access("lw_fast", 1, 0, 2'd2, 0, 32'h1004, 32'd0, 32'h12345678, 0, 0);
        do_access("sb", 0, 1, 2'd0, 0, 32'h2001, 32'h000000ab, 32'd0, 0, 1);
        do_access("sh", 0, 1, 2'd1, 0, 32'h2002, 32'h00001234, 32'd0, 0, 1);
        do_access("ld_st", 1, 1, 2'd3, 0, 32'h2008, 32'hcafef00d, 32'd0, 1, 0);
        check("lh literal", exp_load(2'd1, 1, 32'h1002, 32'h80015a5a), 32'hffff8001);

        // Misaligned accesses
        do_misaligned("mis_lw", 1, 0, 2'd2, 32'h1002, 1, 0);
        do_misaligned("mis_sh", 0, 1, 2'd1, 32'h2001, 0, 1);
        do_misaligned("mis_lh", 1, 0, 2'd1, 32'h3003, 1, 0);

        // Known value before the drain test
        do_access("lw_pre", 1, 0, 2'd2, 0, 32'h1010, 32'd0, 32'h0badcafe, 0, 1);

        // addr_ok withheld, then flush in WAIT, then drain
        @(negedge clk);
        mem_load = 1'b1; mem_size = 2'd2; mem_addr = 32'h3000;
        #1;
        check("drain idle_stall", 32'(data_stall), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            #1;
            check("hold req", 32'(data_sram_req), 32'd1);
            check("hold addr", data_sram_addr, 32'h3000);
            check("hold stall", 32'(data_stall), 32'd1);
        end
        @(negedge clk);
        data_sram_addr_ok = 1'b1;
        #1;
        check("drain accept req", 32'(data_sram_req), 32'd1);
        @(negedge clk);
        data_sram_addr_ok = 1'b0; exception = 1'b1;
        #1;
        check("wait_exc req", 32'(data_sram_req), 32'd0);
        check("wait_exc stall", 32'(data_stall), 32'd1);
        @(negedge clk);
        mem_load = 1'b0;
        #1;
        check("drain stall", 32'(data_stall), 32'd1);
        check("drain req", 32'(data_sram_req), 32'd0);
        @(negedge clk);
        exception = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hdeadbeef;
        #1;
        check("drain dok stall", 32'(data_stall), 32'd1);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        check("drain load_data", mem_load_data, model_load_data);
        check("drain end stall", 32'(data_stall), 32'd0);
        check("drain end req", 32'(data_sram_req), 32'd0);

        // Flush before addr_ok withdraws the request
        @(negedge clk);
        mem_load = 1'b1; mem_size = 2'd2; mem_addr = 32'h3100;
        @(negedge clk);
        exception = 1'b1;
        #1;
        check("req_exc req", 32'(data_sram_req), 32'd1);
        @(negedge clk);
        exception = 1'b0; mem_load = 1'b0;
        #1;
        check("req_exc dropped", 32'(data_sram_req), 32'd0);
        check("req_exc stall", 32'(data_stall), 32'd0);

        // Asynchronous reset in WAIT
        @(negedge clk);
        mem_load = 1'b1; mem_size = 2'd2; mem_addr = 32'h1000;
        @(negedge clk);
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_load_data = 32'd0;
        check("rst req", 32'(data_sram_req), 32'd0);
        check("rst stall", 32'(data_stall), 32'd0);
        check("rst load_data", mem_load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_load = 1'b0;
        #1;
        check("rst release stall", 32'(data_stall), 32'd0);
        do_access("lw_after_rst", 1, 0, 2'd2, 0, 32'h1000, 32'd0, 32'h13579bdf, 0, 1);

        // Randomized aligned accesses
        for (int n = 0; n < 30; n++) begin
            bit          ld, st, sext;
            logic [1:0]  sz;
            logic [31:0] addr;
            int          kind;
            kind = $urandom_range(0, 2);
            ld   = (kind != 1);
            st   = (kind != 0);
            sz   = 2'($urandom_range(0, 3));
            sext = 1'($urandom_range(0, 1));
            addr = $urandom & ~(32'(bytes_of(sz)) - 32'd1);
            do_access("rand", ld, st, sz, sext, addr, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
